// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: IF stage plus IF/ID pipeline register of the pipelined MIPS core.
// A boot loader first writes the program into instruction RAM. Fetch then runs
// until a HALT word reaches decode.
// Ports:
//   clk, rst_n                      core clock, asynchronous active-low reset
//   load_valid/load_data/load_done  boot loader word stream and completion strobe
//   imem_addr/imem_wdata/imem_we    instruction RAM port (combinational, same-cycle read)
//   imem_rdata                      RAM read data for imem_addr
//   stall                           hold PC and IF/ID (load-use hazard)
//   branch_taken/branch_target      redirect from EX; flushes the wrong-path fetch
//   pc                              current fetch PC
//   if_id_instr/if_id_pc4/if_id_valid  registered instruction, PC+4 and valid to decode
//   halted                          fetch stopped on HALT_INSTR
//   load_overflow, misalign_err     sticky error flags
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] HALT_INSTR = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_done,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        imem_we,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        load_overflow,
    output logic        misalign_err
);

    // One extra bit so the pointer can sit at IMEM_WORDS once memory is full.
    localparam int unsigned PTR_W = $clog2(IMEM_WORDS) + 1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   load_ptr_q, load_ptr_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        if_id_instr_q, if_id_instr_d;
    logic [31:0]        if_id_pc4_q, if_id_pc4_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               halted_q, halted_d;
    logic               load_overflow_q, load_overflow_d;
    logic               misalign_err_q, misalign_err_d;
    logic               ptr_in_range;
    logic [31:0]        pc_plus4;

    assign ptr_in_range = (load_ptr_q < PTR_W'(IMEM_WORDS));
    assign pc_plus4     = pc_q + 32'd4;

    // Next-state, RAM port and pipeline-register update logic.
    always_comb begin
        state_d         = state_q;
        load_ptr_d      = load_ptr_q;
        pc_d            = pc_q;
        if_id_instr_d   = if_id_instr_q;
        if_id_pc4_d     = if_id_pc4_q;
        if_id_valid_d   = if_id_valid_q;
        halted_d        = halted_q;
        load_overflow_d = load_overflow_q;
        misalign_err_d  = misalign_err_q;
        imem_addr       = pc_q;
        imem_wdata      = 32'd0;
        imem_we         = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                imem_addr  = 32'({load_ptr_q, 2'b00});
                imem_wdata = load_data;
                imem_we    = load_valid && ptr_in_range;
                if (load_valid) begin
                    if (ptr_in_range) begin
                        load_ptr_d = load_ptr_q + PTR_W'(1);
                    end else begin
                        load_overflow_d = 1'b1;
                    end
                end
                if (load_done) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                // Branch redirect flushes IF/ID and overrides a concurrent stall.
                if (branch_taken) begin
                    pc_d          = {branch_target[31:2], 2'b00};
                    if_id_valid_d = 1'b0;
                    if (branch_target[1:0] != 2'b00) begin
                        misalign_err_d = 1'b1;
                    end
                end else if (!stall) begin
                    if_id_instr_d = imem_rdata;
                    if_id_pc4_d   = pc_plus4;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_plus4;
                    if (imem_rdata == HALT_INSTR) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                // Everything frozen until reset.
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_LOAD;
            load_ptr_q      <= '0;
            pc_q            <= RESET_PC;
            if_id_instr_q   <= 32'd0;
            if_id_pc4_q     <= 32'd0;
            if_id_valid_q   <= 1'b0;
            halted_q        <= 1'b0;
            load_overflow_q <= 1'b0;
            misalign_err_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            load_ptr_q      <= load_ptr_d;
            pc_q            <= pc_d;
            if_id_instr_q   <= if_id_instr_d;
            if_id_pc4_q     <= if_id_pc4_d;
            if_id_valid_q   <= if_id_valid_d;
            halted_q        <= halted_d;
            load_overflow_q <= load_overflow_d;
            misalign_err_q  <= misalign_err_d;
        end
    end

    assign pc            = pc_q;
    assign if_id_instr   = if_id_instr_q;
    assign if_id_pc4     = if_id_pc4_q;
    assign if_id_valid   = if_id_valid_q;
    assign halted        = halted_q;
    assign load_overflow = load_overflow_q;
    assign misalign_err  = misalign_err_q;

endmodule
